// File: rtl/mem_stage_ls_if.sv
// EX/MEM -> MEM/WB stage bus for mem_stage_ls.
// The slave side is the MEM stage itself; the master side is whatever drives
// the EX/MEM slot and consumes the MEM/WB register.
interface mem_stage_ls_if;
  // EX/MEM slot
  logic        in_valid;
  logic        mem_read;
  logic [1:0]  mem_write;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [4:0]  rd_in;
  logic        hold;
  // stall back to EX/MEM
  logic        busy;
  // MEM/WB register
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  modport slave (
    input  in_valid, mem_read, mem_write, load_size, load_unsigned, addr,
           store_data, reg_write_in, mem_to_reg_in, rd_in, hold,
    output busy, wb_valid, wb_reg_write, wb_rd, wb_data, misalign
  );

  modport master (
    output in_valid, mem_read, mem_write, load_size, load_unsigned, addr,
           store_data, reg_write_in, mem_to_reg_in, rd_in, hold,
    input  busy, wb_valid, wb_reg_write, wb_rd, wb_data, misalign
  );
endinterface

// File: rtl/mem_stage_ls.sv
// Pipeline MEM stage: byte-enabled little-endian data memory with byte/half/word
// loads and stores, sign/zero extension, misalignment detection and optional
// wait states. Results land in the MEM/WB register.
module mem_stage_ls #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_ls_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        commit;

  logic        access;
  logic        is_store;
  logic [1:0]  acc_size;
  logic        misaligned;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [15:0] half_v;
  logic [31:0] extracted;
  logic [31:0] load_result;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        mem_we;

  logic [31:0] mem [DEPTH];

  // Decode the access: size, alignment and word index (upper bits wrap).
  always_comb begin
    is_store = (bus.mem_write != 2'b00);
    access   = bus.in_valid & (bus.mem_read | is_store);
    if (is_store)
      acc_size = bus.mem_write;
    else if (bus.load_size == 2'b00)
      acc_size = 2'b11;
    else
      acc_size = bus.load_size;
    misaligned = access & (((acc_size == 2'b10) & bus.addr[0]) |
                           ((acc_size == 2'b11) & (bus.addr[1:0] != 2'b00)));
    idx = bus.addr[AW+1:2];
  end

  assign rd_word = mem[idx];

  // Right-justify the selected lane(s) and extend; a store suppresses the load.
  always_comb begin
    shifted   = rd_word >> {bus.addr[1:0], 3'b000};
    half_v    = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
    extracted = rd_word;
    case (acc_size)
      2'b01:   extracted = bus.load_unsigned ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
      2'b10:   extracted = bus.load_unsigned ? {16'd0, half_v}
                                             : {{16{half_v[15]}}, half_v};
      default: extracted = rd_word;
    endcase
    load_result = (bus.mem_read & ~is_store & ~misaligned) ? extracted : 32'd0;
  end

  // Store lane enables and replicated write data.
  always_comb begin
    be    = 4'b1111;
    wdata = bus.store_data;
    case (acc_size)
      2'b01: begin
        be    = 4'b0001 << bus.addr[1:0];
        wdata = {4{bus.store_data[7:0]}};
      end
      2'b10: begin
        be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.store_data;
      end
    endcase
  end

  // Next state, commit strobe and stall; everything freezes while hold is high.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    if (!bus.hold) begin
      case (state_reg)
        S_IDLE: begin
          if (access && HAS_WAIT) begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            commit = 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_next = cnt_reg - 4'd1;
          end else begin
            commit     = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    bus.busy = bus.hold |
               ((state_reg == S_IDLE) & access & HAS_WAIT) |
               ((state_reg == S_WAIT) & (cnt_reg != 4'd0));
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Reset gates the write so an aborted access never reaches the array.
  assign mem_we = commit & access & is_store & ~misaligned & ~rst;

  // Byte-enabled array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // MEM/WB register: load on commit, bubble while stalling, freeze on hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_valid     <= 1'b0;
      bus.wb_reg_write <= 1'b0;
      bus.wb_rd        <= 5'd0;
      bus.wb_data      <= 32'd0;
      bus.misalign     <= 1'b0;
    end else if (commit) begin
      bus.wb_valid     <= bus.in_valid;
      bus.wb_reg_write <= bus.in_valid & bus.reg_write_in & ~misaligned;
      bus.wb_rd        <= bus.rd_in;
      bus.wb_data      <= bus.mem_to_reg_in ? load_result : bus.addr;
      bus.misalign     <= misaligned;
    end else if (!bus.hold) begin
      bus.wb_valid     <= 1'b0;
      bus.wb_reg_write <= 1'b0;
      bus.misalign     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls: one zero-wait instance and one with two
// wait states, each checked against hand-computed values.
module tb_mem_stage_ls;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mem_stage_ls_if if0();
  mem_stage_ls_if if2();

  mem_stage_ls #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mem_stage_ls #(.DEPTH(1024), .WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to the zero-wait instance and clock it through.
  task automatic drv0(input logic rdq, input logic [1:0] wr, input logic [1:0] ls,
                      input logic lu, input logic [31:0] a, input logic [31:0] sd,
                      input logic rw, input logic m2r, input logic [4:0] rd);
    if0.in_valid      = 1'b1;
    if0.mem_read      = rdq;
    if0.mem_write     = wr;
    if0.load_size     = ls;
    if0.load_unsigned = lu;
    if0.addr          = a;
    if0.store_data    = sd;
    if0.reg_write_in  = rw;
    if0.mem_to_reg_in = m2r;
    if0.rd_in         = rd;
    $display("txn dut0 rd=%0b wr=%b ls=%b lu=%0b addr=%h sd=%h rw=%0b m2r=%0b rd=%0d",
             rdq, wr, ls, lu, a, sd, rw, m2r, rd);
    tick();
  endtask

  // Present one instruction to the wait-state instance; no clocking.
  task automatic drv2(input logic rdq, input logic [1:0] wr, input logic [1:0] ls,
                      input logic lu, input logic [31:0] a, input logic [31:0] sd,
                      input logic rw, input logic m2r, input logic [4:0] rd);
    if2.in_valid      = 1'b1;
    if2.mem_read      = rdq;
    if2.mem_write     = wr;
    if2.load_size     = ls;
    if2.load_unsigned = lu;
    if2.addr          = a;
    if2.store_data    = sd;
    if2.reg_write_in  = rw;
    if2.mem_to_reg_in = m2r;
    if2.rd_in         = rd;
    $display("txn dut2 rd=%0b wr=%b ls=%b lu=%0b addr=%h sd=%h rw=%0b m2r=%0b rd=%0d",
             rdq, wr, ls, lu, a, sd, rw, m2r, rd);
    #1;
  endtask

  // Clock the wait-state instance until it accepts the presented instruction.
  task automatic run2();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!if2.busy) begin
        tick();
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("run2_done", 32'(done), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    if0.in_valid = 0; if0.mem_read = 0; if0.mem_write = 0; if0.load_size = 0;
    if0.load_unsigned = 0; if0.addr = 0; if0.store_data = 0; if0.reg_write_in = 0;
    if0.mem_to_reg_in = 0; if0.rd_in = 0; if0.hold = 0;
    if2.in_valid = 0; if2.mem_read = 0; if2.mem_write = 0; if2.load_size = 0;
    if2.load_unsigned = 0; if2.addr = 0; if2.store_data = 0; if2.reg_write_in = 0;
    if2.mem_to_reg_in = 0; if2.rd_in = 0; if2.hold = 0;
    repeat (2) tick();
    chk("rst_wb_valid", 32'(if0.wb_valid), 32'd0);
    chk("rst_wb_data", if0.wb_data, 32'd0);
    chk("rst_misalign", 32'(if0.misalign), 32'd0);
    chk("rst_busy0", 32'(if0.busy), 32'd0);
    chk("rst_busy2", 32'(if2.busy), 32'd0);
    chk("rst_wb_rd2", 32'(if2.wb_rd), 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- zero wait states ----------------
    drv0(0, 2'b11, 2'b00, 0, 32'h10, 32'h80FF_7F01, 0, 0, 5'd1);
    chk("sw_valid", 32'(if0.wb_valid), 32'd1);
    chk("sw_passthru", if0.wb_data, 32'h10);
    chk("sw_busy", 32'(if0.busy), 32'd0);
    drv0(1, 2'b00, 2'b01, 0, 32'h12, 0, 1, 1, 5'd5);
    chk("lb_12", if0.wb_data, 32'hFFFF_FFFF);
    chk("lb_12_rw", 32'(if0.wb_reg_write), 32'd1);
    chk("lb_12_rd", 32'(if0.wb_rd), 32'd5);
    drv0(1, 2'b00, 2'b01, 0, 32'h11, 0, 1, 1, 5'd6);
    chk("lb_11", if0.wb_data, 32'h0000_007F);
    drv0(1, 2'b00, 2'b01, 1, 32'h13, 0, 1, 1, 5'd7);
    chk("lbu_13", if0.wb_data, 32'h0000_0080);
    drv0(1, 2'b00, 2'b10, 0, 32'h10, 0, 1, 1, 5'd7);
    chk("lh_10", if0.wb_data, 32'h0000_7F01);
    drv0(1, 2'b00, 2'b10, 1, 32'h12, 0, 1, 1, 5'd7);
    chk("lhu_12", if0.wb_data, 32'h0000_80FF);
    drv0(1, 2'b00, 2'b10, 0, 32'h12, 0, 1, 1, 5'd7);
    chk("lh_12", if0.wb_data, 32'hFFFF_80FF);
    drv0(1, 2'b00, 2'b00, 1, 32'h10, 0, 1, 1, 5'd7);
    chk("lsz00_word", if0.wb_data, 32'h80FF_7F01);

    drv0(0, 2'b11, 2'b00, 0, 32'h20, 32'h1234_5678, 0, 0, 5'd0);
    drv0(0, 2'b10, 2'b00, 0, 32'h22, 32'hAAAA_BEEF, 0, 0, 5'd0);
    drv0(1, 2'b00, 2'b11, 0, 32'h20, 0, 1, 1, 5'd9);
    chk("sh_lw_20", if0.wb_data, 32'hBEEF_5678);
    drv0(1, 2'b00, 2'b10, 0, 32'h22, 0, 1, 1, 5'd9);
    chk("lh_22", if0.wb_data, 32'hFFFF_BEEF);

    drv0(0, 2'b10, 2'b00, 0, 32'h21, 32'h0000_1111, 1, 0, 5'd3);
    chk("mis_sh_flag", 32'(if0.misalign), 32'd1);
    chk("mis_sh_rw", 32'(if0.wb_reg_write), 32'd0);
    chk("mis_sh_data", if0.wb_data, 32'h21);
    drv0(1, 2'b00, 2'b11, 0, 32'h26, 0, 1, 1, 5'd4);
    chk("mis_lw_flag", 32'(if0.misalign), 32'd1);
    chk("mis_lw_rw", 32'(if0.wb_reg_write), 32'd0);
    chk("mis_lw_data", if0.wb_data, 32'd0);
    drv0(1, 2'b00, 2'b11, 0, 32'h20, 0, 1, 1, 5'd4);
    chk("mis_unchanged", if0.wb_data, 32'hBEEF_5678);
    chk("mis_cleared", 32'(if0.misalign), 32'd0);

    drv0(0, 2'b01, 2'b00, 0, 32'h21, 32'h0000_0099, 0, 0, 5'd0);
    drv0(1, 2'b00, 2'b11, 0, 32'h20, 0, 1, 1, 5'd4);
    chk("sb_lw_20", if0.wb_data, 32'hBEEF_9978);

    drv0(1, 2'b01, 2'b11, 0, 32'h30, 32'h0000_00AB, 1, 1, 5'd2);
    chk("ld_st_zero", if0.wb_data, 32'd0);
    drv0(1, 2'b00, 2'b01, 1, 32'h30, 0, 1, 1, 5'd2);
    chk("ld_st_stored", if0.wb_data, 32'h0000_00AB);

    if0.in_valid = 1'b0;
    $display("txn dut0 bubble");
    tick();
    chk("bub_valid", 32'(if0.wb_valid), 32'd0);
    chk("bub_rw", 32'(if0.wb_reg_write), 32'd0);
    chk("bub_misalign", 32'(if0.misalign), 32'd0);

    drv0(0, 2'b11, 2'b00, 0, 32'h0000_1004, 32'hCAFE_F00D, 0, 0, 5'd0);
    drv0(1, 2'b00, 2'b11, 0, 32'h4, 0, 1, 1, 5'd1);
    chk("wrap_lw_4", if0.wb_data, 32'hCAFE_F00D);
    if0.in_valid = 1'b0;

    // ---------------- two wait states ----------------
    drv2(0, 2'b11, 2'b00, 0, 32'h40, 32'h0BAD_BEEF, 0, 0, 5'd0);
    run2();

    drv2(1, 2'b00, 2'b11, 0, 32'h40, 0, 1, 1, 5'd7);
    chk("ws_busy_c0", 32'(if2.busy), 32'd1);
    tick();
    chk("ws_busy_c1", 32'(if2.busy), 32'd1);
    chk("ws_valid_c1", 32'(if2.wb_valid), 32'd0);
    tick();
    chk("ws_busy_c2", 32'(if2.busy), 32'd0);
    chk("ws_valid_c2", 32'(if2.wb_valid), 32'd0);
    tick();
    chk("ws_valid_c3", 32'(if2.wb_valid), 32'd1);
    chk("ws_data_c3", if2.wb_data, 32'h0BAD_BEEF);
    chk("ws_rd_c3", 32'(if2.wb_rd), 32'd7);
    chk("ws_rw_c3", 32'(if2.wb_reg_write), 32'd1);

    drv2(0, 2'b00, 2'b00, 0, 32'h1234, 0, 1, 0, 5'd10);
    chk("alu_busy", 32'(if2.busy), 32'd0);
    tick();
    chk("alu_valid", 32'(if2.wb_valid), 32'd1);
    chk("alu_data", if2.wb_data, 32'h1234);
    chk("alu_rd", 32'(if2.wb_rd), 32'd10);

    drv2(1, 2'b00, 2'b11, 0, 32'h40, 0, 1, 1, 5'd8);
    tick();
    chk("hold_pre_valid", 32'(if2.wb_valid), 32'd0);
    if2.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_cnt", 32'(dut2.cnt_reg), 32'd1);
      chk("hold_valid", 32'(if2.wb_valid), 32'd0);
      chk("hold_busy", 32'(if2.busy), 32'd1);
    end
    if2.hold = 1'b0;
    tick();
    chk("hold_e5_valid", 32'(if2.wb_valid), 32'd0);
    tick();
    chk("hold_e6_valid", 32'(if2.wb_valid), 32'd1);
    chk("hold_e6_data", if2.wb_data, 32'h0BAD_BEEF);
    chk("hold_e6_rd", 32'(if2.wb_rd), 32'd8);

    if2.in_valid = 1'b0;
    if2.hold = 1'b1;
    tick();
    chk("hold_wb_valid", 32'(if2.wb_valid), 32'd1);
    chk("hold_wb_rd", 32'(if2.wb_rd), 32'd8);
    chk("hold_wb_data", if2.wb_data, 32'h0BAD_BEEF);
    if2.hold = 1'b0;
    tick();
    chk("unhold_bubble", 32'(if2.wb_valid), 32'd0);

    drv2(1, 2'b00, 2'b11, 0, 32'h40, 0, 1, 1, 5'd12);
    run2();
    chk("pre_rst_data", if2.wb_data, 32'h0BAD_BEEF);
    drv2(0, 2'b11, 2'b00, 0, 32'h40, 32'hDEAD_DEAD, 1, 0, 5'd13);
    tick();
    chk("rst_wait_state", 32'(dut2.state_reg), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_valid", 32'(if2.wb_valid), 32'd0);
    chk("rstw_data", if2.wb_data, 32'd0);
    chk("rstw_rd", 32'(if2.wb_rd), 32'd0);
    chk("rstw_cnt", 32'(dut2.cnt_reg), 32'd0);
    if2.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    drv2(1, 2'b00, 2'b11, 0, 32'h40, 0, 1, 1, 5'd11);
    run2();
    chk("rstw_mem_kept", if2.wb_data, 32'h0BAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
